// File: rtl/svc_soc_io_arbiter_if.sv
// Single-beat request/response channel between one master and the SoC I/O arbiter.
// valid/ready request handshake with posted writes and a one-cycle read-data pulse.
interface svc_soc_io_arbiter_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output valid, we, addr, wdata, wstrb,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata, wstrb,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/svc_soc_io_arbiter.sv
// Two-master arbiter (CPU on m0, debug bridge on m1) in front of the SoC I/O register bank.
// One transaction in flight at a time; reads return on the owner's rvalid pulse.
module svc_soc_io_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  svc_soc_io_arbiter_if.slave        m0,
  svc_soc_io_arbiter_if.slave        m1,
  output logic                       io_ren,
  output logic [31:0]                io_raddr,
  input  logic [31:0]                io_rdata,
  output logic                       io_wen,
  output logic [31:0]                io_waddr,
  output logic [31:0]                io_wdata,
  output logic [3:0]                 io_wstrb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] LAT      = 3'(RD_LATENCY);
  localparam bit         LAT_ZERO = (RD_LATENCY == 0);

  state_t      state_r;
  logic        last_grant_r;
  logic        owner_r;
  logic        we_r;
  logic [2:0]  cnt_r;
  logic        m0_rvalid_r;
  logic        m1_rvalid_r;
  logic [31:0] m0_rdata_r;
  logic [31:0] m1_rdata_r;
  logic        io_ren_r;
  logic        io_wen_r;
  logic [31:0] io_raddr_r;
  logic [31:0] io_waddr_r;
  logic [31:0] io_wdata_r;
  logic [3:0]  io_wstrb_r;

  logic        grant0_s;
  logic        grant1_s;
  logic        capture_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic [3:0]  sel_wstrb_s;

  // Grant decision: only in IDLE, ties resolved by fixed priority or by last_grant.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst && (state_r == ST_IDLE)) begin
      if (m0.valid && m1.valid) begin
        if (FIXED_PRIO || last_grant_r) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else if (m0.valid) begin
        grant0_s = 1'b1;
      end else if (m1.valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Request field mux and read-data capture strobe.
  always_comb begin
    if (grant1_s) begin
      sel_we_s    = m1.we;
      sel_addr_s  = m1.addr;
      sel_wdata_s = m1.wdata;
      sel_wstrb_s = m1.wstrb;
    end else begin
      sel_we_s    = m0.we;
      sel_addr_s  = m0.addr;
      sel_wdata_s = m0.wdata;
      sel_wstrb_s = m0.wstrb;
    end
    // A zero-latency bank answers in the strobe cycle itself.
    capture_s = !we_r && (((state_r == ST_ISSUE) && LAT_ZERO) ||
                          ((state_r == ST_WAIT) && (cnt_r <= 3'd1)));
  end

  // Transaction FSM with registered bank strobes and read responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      we_r         <= 1'b0;
      cnt_r        <= 3'd0;
      m0_rvalid_r  <= 1'b0;
      m1_rvalid_r  <= 1'b0;
      m0_rdata_r   <= 32'd0;
      m1_rdata_r   <= 32'd0;
      io_ren_r     <= 1'b0;
      io_wen_r     <= 1'b0;
      io_raddr_r   <= 32'd0;
      io_waddr_r   <= 32'd0;
      io_wdata_r   <= 32'd0;
      io_wstrb_r   <= 4'd0;
    end else begin
      io_ren_r    <= 1'b0;
      io_wen_r    <= 1'b0;
      m0_rvalid_r <= 1'b0;
      m1_rvalid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant0_s || grant1_s) begin
            owner_r      <= grant1_s;
            last_grant_r <= grant1_s;
            we_r         <= sel_we_s;
            if (sel_we_s) begin
              io_wen_r   <= 1'b1;
              io_waddr_r <= sel_addr_s;
              io_wdata_r <= sel_wdata_s;
              io_wstrb_r <= sel_wstrb_s;
            end else begin
              io_ren_r   <= 1'b1;
              io_raddr_r <= sel_addr_s;
            end
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (we_r || LAT_ZERO) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r   <= LAT;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r <= 3'd1) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (capture_s) begin
        if (owner_r) begin
          m1_rvalid_r <= 1'b1;
          m1_rdata_r  <= io_rdata;
        end else begin
          m0_rvalid_r <= 1'b1;
          m0_rdata_r  <= io_rdata;
        end
      end
    end
  end

  assign m0.ready  = grant0_s;
  assign m1.ready  = grant1_s;
  assign m0.rvalid = m0_rvalid_r;
  assign m1.rvalid = m1_rvalid_r;
  assign m0.rdata  = m0_rdata_r;
  assign m1.rdata  = m1_rdata_r;
  assign io_ren    = io_ren_r;
  assign io_wen    = io_wen_r;
  assign io_raddr  = io_raddr_r;
  assign io_waddr  = io_waddr_r;
  assign io_wdata  = io_wdata_r;
  assign io_wstrb  = io_wstrb_r;

endmodule
